// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers; latency MULT_CYCLES or DIV_CYCLES busy cycles.
// Busy stalls the front end; Start, mthi and mtlo issued while busy are dropped.
module mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        HIWrite,
    input  logic        LOWrite,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXN + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, r_limit;
    logic [63:0]   r_temp;
    logic          r_skip;
    logic          w_launch, w_done;

    logic          w_a_neg, w_b_neg, w_b_zero;
    logic [31:0]   w_a_mag, w_b_mag, w_div_s, w_div_u;
    logic [31:0]   w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
    logic [63:0]   w_prod_s, w_prod_u, w_result;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows D1.
    // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
    assign w_a_neg  = D1[31];
    assign w_b_neg  = D2[31];
    assign w_b_zero = (D2 == 32'd0);
    assign w_a_mag  = w_a_neg ? (32'd0 - D1) : D1;
    assign w_b_mag  = w_b_neg ? (32'd0 - D2) : D2;
    assign w_div_s  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_div_u  = w_b_zero ? 32'd1 : D2;
    assign w_q_mag  = w_a_mag / w_div_s;
    assign w_r_mag  = w_a_mag % w_div_s;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u    = D1 / w_div_u;
    assign w_r_u    = D1 % w_div_u;
    assign w_prod_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
    assign w_prod_u = {32'd0, D1} * {32'd0, D2};

    always_comb begin
        w_result = w_prod_s;
        case (Op)
            2'b00: w_result = w_prod_s;
            2'b01: w_result = w_prod_u;
            2'b10: w_result = {w_r_s, w_q_s};
            2'b11: w_result = {w_r_u, w_q_u};
            default: w_result = w_prod_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == r_limit) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_limit <= '0;
            r_temp  <= '0;
            r_skip  <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (w_launch) begin
            r_temp  <= w_result;
            r_cnt   <= CW'(1);
            r_limit <= Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_skip  <= Op[1] & w_b_zero;
        end else if (r_state == S_BUSY) begin
            if (w_done) begin
                r_cnt <= '0;
                if (!r_skip) {HI, LO} <= r_temp;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            if (HIWrite) HI <= D1;
            if (LOWrite) LO <= D1;
        end
    end

    assign Busy = (r_state == S_BUSY);
endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div: arithmetic, busy timing, collisions and reset.
module tb_mult_div;
    logic        clk = 1'b0;
    logic        reset, Start, HIWrite, LOWrite;
    logic [1:0]  Op;
    logic [31:0] D1, D2;
    logic        Busy;
    logic [31:0] HI, LO;
    int          checks = 0;
    int          failures = 0;

    mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; D1 = a; D2 = b;
        tick();
        Start = 1'b0; D1 = 32'h0; D2 = 32'h0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
        checks++; if (HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", HI); end
        checks++; if (LO !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", LO); end
    endtask

    task automatic test_mult();
        int n;
        do_start(2'b00, 32'hFFFFFFFD, 32'd5);
        checks++; if (LO !== 32'h0) begin failures++; $display("FAIL mult_lo_held got=%h exp=00000000", LO); end
        count_busy(n);
        checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", LO); end
    endtask

    task automatic test_multu();
        int n;
        do_start(2'b01, 32'hFFFFFFFF, 32'd2);
        count_busy(n);
        checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        checks++; if (HI !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
    endtask

    task automatic test_div();
        int n;
        do_start(2'b10, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        checks++; if (n != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        checks++; if (LO !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
        do_start(2'b10, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        checks++; if (LO !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
        checks++; if (HI !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", HI); end
    endtask

    task automatic test_mthi_mtlo_divzero();
        int n;
        HIWrite = 1'b1; LOWrite = 1'b1; D1 = 32'h0000ABCD; tick();
        HIWrite = 1'b0; LOWrite = 1'b0;
        checks++; if (HI !== 32'h0000ABCD || LO !== 32'h0000ABCD) begin
            failures++; $display("FAIL mthi_mtlo_both got=%h/%h exp=0000abcd/0000abcd", HI, LO);
        end
        HIWrite = 1'b1; D1 = 32'h1234; tick(); HIWrite = 1'b0;
        LOWrite = 1'b1; D1 = 32'h5678; tick(); LOWrite = 1'b0;
        checks++; if (HI !== 32'h1234 || LO !== 32'h5678 || Busy !== 1'b0) begin
            failures++; $display("FAIL mthi_mtlo got=%h/%h busy=%0b exp=00001234/00005678 busy=0", HI, LO, Busy);
        end
        do_start(2'b11, 32'd7, 32'd0);
        count_busy(n);
        checks++; if (n != 10) begin failures++; $display("FAIL divzero_busy_cycles got=%0d exp=10", n); end
        checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin
            failures++; $display("FAIL divzero_hilo got=%h/%h exp=00001234/00005678", HI, LO);
        end
        do_start(2'b11, 32'd100, 32'd7);
        count_busy(n);
        checks++; if (HI !== 32'd2 || LO !== 32'd14) begin
            failures++; $display("FAIL divu_hilo got=%h/%h exp=00000002/0000000e", HI, LO);
        end
    endtask

    task automatic test_collision();
        int n;
        do_start(2'b00, 32'd3, 32'd4);
        tick();
        Start = 1'b1; Op = 2'b10; D1 = 32'd100; D2 = 32'd7; HIWrite = 1'b1;
        tick();
        Start = 1'b0; HIWrite = 1'b0; D1 = 32'h0; D2 = 32'h0;
        count_busy(n);
        checks++; if (n != 3) begin failures++; $display("FAIL collide_remaining_busy got=%0d exp=3", n); end
        checks++; if (HI !== 32'h0 || LO !== 32'd12) begin
            failures++; $display("FAIL collide_hilo got=%h/%h exp=00000000/0000000c", HI, LO);
        end
        tick();
        checks++; if (Busy !== 1'b0 || LO !== 32'd12) begin
            failures++; $display("FAIL collide_no_relaunch busy=%0b lo=%h exp busy=0 lo=0000000c", Busy, LO);
        end
        Start = 1'b1; Op = 2'b00; D1 = 32'd2; D2 = 32'd3; HIWrite = 1'b1; LOWrite = 1'b1;
        tick();
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
        checks++; if (Busy !== 1'b1 || HI !== 32'h0 || LO !== 32'd12) begin
            failures++; $display("FAIL start_beats_mtx busy=%0b hi=%h lo=%h exp busy=1 hi=00000000 lo=0000000c", Busy, HI, LO);
        end
        count_busy(n);
        checks++; if (HI !== 32'h0 || LO !== 32'd6) begin
            failures++; $display("FAIL start_beats_mtx_result got=%h/%h exp=00000000/00000006", HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        do_start(2'b10, 32'd100, 32'd7);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            failures++; $display("FAIL reset_mid busy=%0b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, HI, LO);
        end
        for (int i = 0; i < 12; i++) tick();
        checks++; if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            failures++; $display("FAIL reset_no_late_write busy=%0b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        do_start(2'b00, 32'd7, 32'd6);
        count_busy(n1);
        checks++; if (n1 != 5 || LO !== 32'd42) begin
            failures++; $display("FAIL b2b_first busy=%0d lo=%h exp busy=5 lo=0000002a", n1, LO);
        end
        do_start(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFE);
        count_busy(n2);
        checks++; if (n2 != 5) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=5", n2); end
        checks++; if (HI !== 32'h0 || LO !== 32'd4) begin
            failures++; $display("FAIL b2b_second_hilo got=%h/%h exp=00000000/00000004", HI, LO);
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Op = 2'b00; D1 = 32'h0; D2 = 32'h0;
        HIWrite = 1'b0; LOWrite = 1'b0;
        #1;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo_divzero();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
